// File: rtl/fp_pkg.sv
// Shared types and helpers for the sequential FP multiplier.
// Special-value builders return a wide word; callers truncate to W.
package fp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_MULT,
        S_NORM,
        S_ROUND
    } state_t;

    localparam int MAX_W = 64;

    function automatic int bias_of(int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int word_w(int exp_w, int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic logic [MAX_W-1:0] fp_nan(int exp_w, int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w)
             | (64'd1 << (man_w - 1));
    endfunction

    function automatic logic [MAX_W-1:0] fp_inf(logic s, int exp_w,
                                                int man_w);
        return (64'(s) << (exp_w + man_w))
             | (((64'd1 << exp_w) - 64'd1) << man_w);
    endfunction

    function automatic logic [MAX_W-1:0] fp_zero(logic s, int exp_w,
                                                 int man_w);
        return 64'(s) << (exp_w + man_w);
    endfunction

endpackage

// File: rtl/fp_mul_seq_mant.sv
// Radix-2 shift-add mantissa multiplier, one multiplier bit per cycle.
// done pulses one cycle after the final partial product is accumulated.
module mant_mult_seq #(
    parameter int N = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] prod,
    output logic           done
);

    localparam int CW = $clog2(N + 1);

    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
            run    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                mcand  <= {{N{1'b0}}, a};
                mplier <= b;
                prod   <= '0;
                cnt    <= CW'(N);
                run    <= 1'b1;
            end else if (run) begin
                if (mplier[0])
                    prod <= prod + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754-style multiplier: unpack, shift-add multiply,
// normalise, round-to-nearest-even, pack, with zero/inf/NaN handling.
module fp_mul_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mul_start,
    input  logic [word_w(EXP_W,MAN_W)-1:0] op1,
    input  logic [word_w(EXP_W,MAN_W)-1:0] op2,
    output logic [word_w(EXP_W,MAN_W)-1:0] mul_result,
    output logic                         mul_done,
    output logic                         mul_busy,
    output logic                         mul_overflow,
    output logic                         mul_underflow,
    output logic                         mul_invalid
);

    localparam int W  = word_w(EXP_W, MAN_W);
    localparam int N  = MAN_W + 1;
    localparam int PW = 2 * N;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS = EW'(bias_of(EXP_W));
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    state_t state, state_nx;

    logic [W-1:0]           a_q, b_q, spec_res_q;
    logic                   sign_q, spec_q, spec_inv_q;
    logic signed [EW-1:0]   exp_q;
    logic [MAN_W-1:0]       frac_q;
    logic                   guard_q, sticky_q;

    logic [EXP_W-1:0]       e1, e2;
    logic [MAN_W-1:0]       f1, f2;
    logic                   nan1, nan2, inf1, inf2, zero1, zero2;
    logic                   sign_c, invalid_c, spec_c;
    logic [W-1:0]           spec_res_c;
    logic signed [EW-1:0]   exp_sum_c;

    logic [PW-1:0]          prod;
    logic                   mult_done, mult_load;
    logic [PW-2:0]          sh_c;

    logic                   inc_c;
    logic [MAN_W:0]         rsum_c;
    logic signed [EW-1:0]   exp_r_c;

    assign e1 = a_q[W-2:MAN_W];
    assign e2 = b_q[W-2:MAN_W];
    assign f1 = a_q[MAN_W-1:0];
    assign f2 = b_q[MAN_W-1:0];

    always_comb begin
        nan1      = (&e1) & (|f1);
        nan2      = (&e2) & (|f2);
        inf1      = (&e1) & ~(|f1);
        inf2      = (&e2) & ~(|f2);
        zero1     = ~(|e1);
        zero2     = ~(|e2);
        sign_c    = a_q[W-1] ^ b_q[W-1];
        invalid_c = nan1 | nan2 | (zero1 & inf2) | (inf1 & zero2);
        spec_c    = invalid_c | inf1 | inf2 | zero1 | zero2;
        exp_sum_c = $signed({2'b00, e1}) + $signed({2'b00, e2}) - BIAS;
        if (invalid_c)
            spec_res_c = W'(fp_nan(EXP_W, MAN_W));
        else if (inf1 | inf2)
            spec_res_c = W'(fp_inf(sign_c, EXP_W, MAN_W));
        else
            spec_res_c = W'(fp_zero(sign_c, EXP_W, MAN_W));
    end

    assign mult_load = (state == S_UNPACK) && !spec_c;

    mant_mult_seq #(.N(N)) u_mant (
        .clk  (clk),
        .rst  (rst),
        .load (mult_load),
        .a    ({1'b1, f1}),
        .b    ({1'b1, f2}),
        .prod (prod),
        .done (mult_done)
    );

    // Align the leading one to bit PW-1 so fraction/guard/sticky taps are fixed.
    assign sh_c = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};

    always_comb begin
        inc_c   = guard_q & (sticky_q | frac_q[0]);
        rsum_c  = {1'b0, frac_q} + {{MAN_W{1'b0}}, inc_c};
        exp_r_c = exp_q + $signed({{(EW-1){1'b0}}, rsum_c[MAN_W]});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (mul_start) state_nx = S_UNPACK;
            S_UNPACK: state_nx = spec_c ? S_ROUND : S_MULT;
            S_MULT:   if (mult_done) state_nx = S_NORM;
            S_NORM:   state_nx = S_ROUND;
            S_ROUND:  state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    assign mul_busy = (state != S_IDLE) | mul_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q           <= '0;
            b_q           <= '0;
            spec_res_q    <= '0;
            sign_q        <= 1'b0;
            spec_q        <= 1'b0;
            spec_inv_q    <= 1'b0;
            exp_q         <= '0;
            frac_q        <= '0;
            guard_q       <= 1'b0;
            sticky_q      <= 1'b0;
            mul_result    <= '0;
            mul_done      <= 1'b0;
            mul_overflow  <= 1'b0;
            mul_underflow <= 1'b0;
            mul_invalid   <= 1'b0;
        end else begin
            mul_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (mul_start) begin
                        a_q <= op1;
                        b_q <= op2;
                    end
                end
                S_UNPACK: begin
                    sign_q     <= sign_c;
                    spec_q     <= spec_c;
                    spec_inv_q <= invalid_c;
                    spec_res_q <= spec_res_c;
                    exp_q      <= exp_sum_c;
                end
                S_NORM: begin
                    frac_q   <= sh_c[PW-2 -: MAN_W];
                    guard_q  <= sh_c[PW-2-MAN_W];
                    sticky_q <= |sh_c[PW-3-MAN_W:0];
                    if (prod[PW-1])
                        exp_q <= exp_q + EW'(1);
                end
                S_ROUND: begin
                    mul_done      <= 1'b1;
                    mul_overflow  <= 1'b0;
                    mul_underflow <= 1'b0;
                    mul_invalid   <= 1'b0;
                    if (spec_q) begin
                        mul_result  <= spec_res_q;
                        mul_invalid <= spec_inv_q;
                    end else if (exp_r_c >= EMAX) begin
                        mul_result   <= W'(fp_inf(sign_q, EXP_W, MAN_W));
                        mul_overflow <= 1'b1;
                    end else if (exp_r_c <= 0) begin
                        mul_result    <= W'(fp_zero(sign_q, EXP_W, MAN_W));
                        mul_underflow <= 1'b1;
                    end else begin
                        mul_result <= {sign_q, exp_r_c[EXP_W-1:0],
                                       rsum_c[MAN_W-1:0]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
